// File: rtl/pipelined_functional_unit_pkg.sv
// Shared opcode set, latency table and countdown sizing
// for the pipelined functional unit.
package pipelined_functional_unit_pkg;

    localparam int MAX_LAT = 4;
    localparam int CD_W    = $clog2(MAX_LAT + 1);

    typedef logic [CD_W-1:0] cd_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_SUB  = 4'b0101,
        OP_SLL  = 4'b1001,
        OP_SRL  = 4'b1010,
        OP_SRA  = 4'b1011,
        OP_PASS = 4'b1111
    } alu_op_e;

    // Unknown opcodes complete immediately.
    function automatic cd_t op_latency(input logic [3:0] op);
        cd_t lat;
        lat = cd_t'(0);
        case (op)
            OP_OR, OP_AND, OP_XOR: lat = cd_t'(1);
            OP_ADD, OP_SUB:        lat = cd_t'(2);
            OP_SLL, OP_SRL:        lat = cd_t'(3);
            OP_SRA:                lat = cd_t'(4);
            default:               lat = cd_t'(0);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational datapath: one result per opcode,
// all-ones plus an illegal flag for unknown opcodes.
module alu_compute
    import pipelined_functional_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] lhs_i,
    input  logic [XLEN-1:0] rhs_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;

    assign shamt = rhs_i[SH_W-1:0];

    always_comb begin
        result_o  = '1;
        illegal_o = 1'b0;
        case (op_i)
            OP_NONE: result_o = '1;
            OP_OR:   result_o = lhs_i | rhs_i;
            OP_ADD:  result_o = lhs_i + rhs_i;
            OP_XOR:  result_o = lhs_i ^ rhs_i;
            OP_AND:  result_o = lhs_i & rhs_i;
            OP_SUB:  result_o = lhs_i - rhs_i;
            OP_SLL:  result_o = lhs_i << shamt;
            OP_SRL:  result_o = lhs_i >> shamt;
            OP_SRA:  result_o = $signed(lhs_i) >>> shamt;
            OP_PASS: result_o = rhs_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_functional_unit.sv
// In-order completion unit: results are computed at dispatch and held
// in a circular slot FIFO until each slot's latency countdown expires.
module pipelined_functional_unit
    import pipelined_functional_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int ROB_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write_enable,
    input  logic [3:0]       ALUControl,
    input  logic             ALUSrc,
    input  logic             is_for_lsq,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_value,
    input  logic [XLEN-1:0]  rs2_value,
    input  logic [TAG_W-1:0] tag_to_output,
    input  logic [ROB_W-1:0] rob_index,
    input  logic             flush,
    output logic             is_available,
    output logic             wakeup_active,
    input  logic             wakeup_ready,
    output logic [TAG_W-1:0] wakeup_tag,
    output logic [ROB_W-1:0] wakeup_rob_index,
    output logic [XLEN-1:0]  wakeup_value,
    output logic             lsq_wakeup_active,
    input  logic             lsq_wakeup_ready,
    output logic [ROB_W-1:0] lsq_wakeup_rob_index,
    output logic [XLEN-1:0]  lsq_wakeup_value,
    output logic             illegal_op
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob;
        logic             lsq;
    } slot_t;

    slot_t            slots_q [DEPTH];
    cd_t              cd_q    [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q;

    logic [XLEN-1:0]  rhs;
    logic [XLEN-1:0]  alu_res;
    logic             alu_ill;
    cd_t              lat;
    slot_t            head;
    logic             head_ok;
    logic             pop;
    logic             accept;

    assign rhs = ALUSrc ? imm : rs2_value;

    alu_compute #(
        .XLEN(XLEN)
    ) u_alu (
        .op_i     (ALUControl),
        .lhs_i    (rs1_value),
        .rhs_i    (rhs),
        .result_o (alu_res),
        .illegal_o(alu_ill)
    );

    assign lat = alu_ill ? cd_t'(0) : op_latency(ALUControl);

    assign head    = slots_q[head_q];
    assign head_ok = (count_q != '0) && (cd_q[head_q] == '0) && !flush;

    assign wakeup_active     = head_ok && !head.lsq;
    assign lsq_wakeup_active = head_ok && head.lsq;

    assign wakeup_tag           = head.tag;
    assign wakeup_rob_index     = head.rob;
    assign wakeup_value         = head.value;
    assign lsq_wakeup_rob_index = head.rob;
    assign lsq_wakeup_value     = head.value;

    assign pop = (wakeup_active && wakeup_ready)
              || (lsq_wakeup_active && lsq_wakeup_ready);

    // A pop frees a slot in the same cycle, so full-and-draining still accepts.
    assign is_available = (count_q != CNT_W'(DEPTH)) || pop;
    assign accept       = write_enable && is_available && !flush;
    assign illegal_op   = illegal_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)
                head_d = head_q + PTR_W'(1);
            if (accept)
                tail_d = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i]    <= '0;
                slots_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            illegal_q <= accept && alu_ill;
            for (int i = 0; i < DEPTH; i++) begin
                if (cd_q[i] != '0)
                    cd_q[i] <= cd_q[i] - cd_t'(1);
            end
            if (accept) begin
                cd_q[tail_q]    <= lat;
                slots_q[tail_q] <= '{
                    value: alu_res,
                    tag:   tag_to_output,
                    rob:   rob_index,
                    lsq:   is_for_lsq
                };
            end
        end
    end

endmodule

// File: tb/tb_pipelined_functional_unit.sv
// Scoreboard bench: a cycle-level queue model predicts every
// presentation, handshake and illegal pulse of the unit.
module tb_pipelined_functional_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int ROB_W = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             write_enable = 1'b0;
    logic [3:0]       ALUControl = 4'h0;
    logic             ALUSrc = 1'b0;
    logic             is_for_lsq = 1'b0;
    logic [XLEN-1:0]  imm = '0;
    logic [XLEN-1:0]  rs1_value = '0;
    logic [XLEN-1:0]  rs2_value = '0;
    logic [TAG_W-1:0] tag_to_output = '0;
    logic [ROB_W-1:0] rob_index = '0;
    logic             flush = 1'b0;
    logic             wakeup_ready = 1'b0;
    logic             lsq_wakeup_ready = 1'b0;

    logic             is_available;
    logic             wakeup_active;
    logic [TAG_W-1:0] wakeup_tag;
    logic [ROB_W-1:0] wakeup_rob_index;
    logic [XLEN-1:0]  wakeup_value;
    logic             lsq_wakeup_active;
    logic [ROB_W-1:0] lsq_wakeup_rob_index;
    logic [XLEN-1:0]  lsq_wakeup_value;
    logic             illegal_op;

    pipelined_functional_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .write_enable        (write_enable),
        .ALUControl          (ALUControl),
        .ALUSrc              (ALUSrc),
        .is_for_lsq          (is_for_lsq),
        .imm                 (imm),
        .rs1_value           (rs1_value),
        .rs2_value           (rs2_value),
        .tag_to_output       (tag_to_output),
        .rob_index           (rob_index),
        .flush               (flush),
        .is_available        (is_available),
        .wakeup_active       (wakeup_active),
        .wakeup_ready        (wakeup_ready),
        .wakeup_tag          (wakeup_tag),
        .wakeup_rob_index    (wakeup_rob_index),
        .wakeup_value        (wakeup_value),
        .lsq_wakeup_active   (lsq_wakeup_active),
        .lsq_wakeup_ready    (lsq_wakeup_ready),
        .lsq_wakeup_rob_index(lsq_wakeup_rob_index),
        .lsq_wakeup_value    (lsq_wakeup_value),
        .illegal_op          (illegal_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int errs  = 0;

    typedef struct {
        logic [31:0] val;
        logic [5:0]  tag;
        logic [5:0]  rob;
        bit          lsq;
        int          rdy;
    } exp_t;

    exp_t sb[$];
    bit   ill_exp = 1'b0;

    logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                             4'h5, 4'h9, 4'hA, 4'hB, 4'hF};

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
        end
    endfunction

    function automatic bit legal(logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                          4'h5, 4'h9, 4'hA, 4'hB, 4'hF};
    endfunction

    function automatic int ref_lat(logic [3:0] op);
        case (op)
            4'h1, 4'h3, 4'h4: return 1;
            4'h2, 4'h5:       return 2;
            4'h9, 4'hA:       return 3;
            4'hB:             return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_res(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sh;
        logic [31:0] ones;
        sh = int'(b % 32);
        ones = 32'hFFFF_FFFF;
        case (op)
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a ^ b;
            4'h4: return a & b;
            4'h5: return a - b;
            4'h9: return a << sh;
            4'hA: return a >> sh;
            4'hB: return a[31] ? ((a >> sh) | ~(ones >> sh)) : (a >> sh);
            4'hF: return b;
            default: return ones;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        bit   pres;
        bit   pop;
        bit   av;
        exp_t e;
        if (!reset_n) begin
            sb.delete();
            ill_exp = 1'b0;
        end else begin
            chk("illegal_op", {31'b0, illegal_op}, {31'b0, ill_exp});
            pres = 1'b0;
            if (sb.size() > 0 && !flush)
                pres = (cyc >= sb[0].rdy);
            chk("wakeup_active", {31'b0, wakeup_active},
                {31'b0, pres && (sb.size() > 0) && !sb[0].lsq});
            chk("lsq_wakeup_active", {31'b0, lsq_wakeup_active},
                {31'b0, pres && (sb.size() > 0) && sb[0].lsq});
            pop = 1'b0;
            if (pres) begin
                e = sb[0];
                if (e.lsq) begin
                    chk("lsq_value", lsq_wakeup_value, e.val);
                    chk("lsq_rob", {26'b0, lsq_wakeup_rob_index}, {26'b0, e.rob});
                    pop = lsq_wakeup_ready;
                end else begin
                    chk("wk_value", wakeup_value, e.val);
                    chk("wk_tag", {26'b0, wakeup_tag}, {26'b0, e.tag});
                    chk("wk_rob", {26'b0, wakeup_rob_index}, {26'b0, e.rob});
                    pop = wakeup_ready;
                end
            end
            av = (sb.size() < DEPTH) || pop;
            chk("is_available", {31'b0, is_available}, {31'b0, av});
            if (pop)
                void'(sb.pop_front());
            ill_exp = 1'b0;
            if (flush) begin
                sb.delete();
            end else if (write_enable && av) begin
                e.val = ref_res(ALUControl, rs1_value, ALUSrc ? imm : rs2_value);
                e.tag = tag_to_output;
                e.rob = rob_index;
                e.lsq = is_for_lsq;
                e.rdy = cyc + 1 + ref_lat(ALUControl);
                sb.push_back(e);
                ill_exp = !legal(ALUControl);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        write_enable = 1'b0;
        repeat (n) step();
    endtask

    task automatic issue(input logic [3:0] op, input bit src, input bit lsq,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [5:0] tg,
                         input logic [5:0] rb);
        write_enable  = 1'b1;
        ALUControl    = op;
        ALUSrc        = src;
        is_for_lsq    = lsq;
        rs1_value     = a;
        rs2_value     = b;
        imm           = im;
        tag_to_output = tg;
        rob_index     = rb;
        step();
        write_enable  = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        wakeup_ready = 1'b1;
        lsq_wakeup_ready = 1'b1;
        idle(2);

        issue(4'h2, 1'b1, 1'b0, 32'd5, 32'd0, 32'd7, 6'd3, 6'd1);
        idle(5);

        issue(4'hB, 1'b0, 1'b0, 32'h8000_0010, 32'd4, 32'd0, 6'd4, 6'd2);
        issue(4'hF, 1'b1, 1'b0, 32'd0, 32'd0, 32'h1000, 6'd5, 6'd3);
        idle(8);

        wakeup_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            issue(4'h1, 1'b0, 1'b0, 32'h10 << i, 32'h1, 32'd0, 6'(10 + i), 6'(i));
        idle(3);
        wakeup_ready = 1'b1;
        issue(4'h1, 1'b1, 1'b0, 32'hA0, 32'd0, 32'h0B, 6'd20, 6'd20);
        idle(8);

        issue(4'h2, 1'b0, 1'b1, 32'd2, 32'd3, 32'd0, 6'd0, 6'd9);
        idle(5);

        issue(4'hB, 1'b0, 1'b0, 32'hF000_0000, 32'd8, 32'd0, 6'd1, 6'd1);
        issue(4'h9, 1'b0, 1'b0, 32'h1, 32'd31, 32'd0, 6'd2, 6'd2);
        issue(4'hA, 1'b0, 1'b0, 32'h8000_0000, 32'd33, 32'd0, 6'd3, 6'd3);
        flush = 1'b1;
        issue(4'h2, 1'b1, 1'b0, 32'd1, 32'd0, 32'd1, 6'd7, 6'd7);
        flush = 1'b0;
        idle(6);

        issue(4'h6, 1'b0, 1'b0, 32'h1234, 32'h5678, 32'd0, 6'd11, 6'd12);
        idle(3);

        issue(4'hB, 1'b0, 1'b0, 32'h8000_0000, 32'd2, 32'd0, 6'd13, 6'd14);
        idle(1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            wakeup_ready     = ($urandom_range(3) != 0);
            lsq_wakeup_ready = ($urandom_range(3) != 0);
            flush            = ($urandom_range(49) == 0);
            reset_n          = ($urandom_range(299) != 0);
            write_enable     = ($urandom_range(9) < 7);
            if ($urandom_range(19) == 0)
                ALUControl = 4'($urandom);
            else
                ALUControl = ops[$urandom_range(9)];
            ALUSrc        = 1'($urandom);
            is_for_lsq    = 1'($urandom);
            rs1_value     = $urandom;
            rs2_value     = $urandom;
            imm           = $urandom;
            tag_to_output = 6'($urandom);
            rob_index     = 6'($urandom);
            step();
        end

        flush = 1'b0;
        reset_n = 1'b1;
        write_enable = 1'b0;
        wakeup_ready = 1'b1;
        lsq_wakeup_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/pipelined_functional_unit.md
PIPELINED_FUNCTIONAL_UNIT -- requirements
Module: pipelined_functional_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter DEPTH, default 4: in-flight op slots; power of two, minimum 2.
REQ-003 Parameter TAG_W, default 6: physical tag width.
REQ-004 Parameter ROB_W, default 6: ROB index width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 write_enable  in  1  dispatch request; accepted only when is_available=1.
REQ-008 ALUControl  in  4  operation code.
REQ-009 ALUSrc  in  1  0 means rhs=rs2_value; 1 means rhs=imm.
REQ-010 is_for_lsq  in  1  result goes to the LSQ bus instead of the wakeup bus.
REQ-011 imm, rs1_value, rs2_value  in  XLEN each  operands.
REQ-012 tag_to_output  in  TAG_W; rob_index  in  ROB_W  identity carried with the op.
REQ-013 flush  in  1  discards every in-flight op.
REQ-014 is_available  out  1  a write this cycle is accepted.
REQ-015 wakeup_active  out  1; wakeup_ready  in  1; wakeup_tag  out  TAG_W; wakeup_rob_index  out  ROB_W; wakeup_value  out  XLEN.
REQ-016 lsq_wakeup_active  out  1; lsq_wakeup_ready  in  1; lsq_wakeup_rob_index  out  ROB_W; lsq_wakeup_value  out  XLEN.
REQ-017 illegal_op  out  1  one-cycle pulse, the cycle after an illegal ALUControl is accepted.

Function
REQ-018 Ops: 0000 NONE (-1), 0001 OR, 0010 ADD, 0011 XOR, 0100 AND, 0101 SUB (lhs-rhs), 1001 SLL, 1010 SRL, 1011 SRA (true sign extension), 1111 pass rhs; lhs=rs1_value.
REQ-019 Shift amount = rhs[$clog2(XLEN)-1:0]; upper rhs bits ignored.
REQ-020 Latency L: NONE 0, OR 1, AND 1, XOR 1, ADD 2, SUB 2, SLL/SRL 3, SRA 4, pass 0.
REQ-021 Any other ALUControl: accepted, result all-ones, L=0, illegal_op pulses; no simulation fatal.
REQ-022 Slots form a circular FIFO, with head/tail pointers and a count of 0..DEPTH; an accepted op is written at the tail with a countdown of L.
REQ-023 Each occupied slot's countdown decrements once per cycle, saturating at 0; the result is computed at accept.
REQ-024 Head becomes presentable when its countdown is 0; an op accepted at edge E with L becomes presentable no earlier than the cycle after edge E+L.
REQ-025 Completion is strictly in order; a younger ready op waits behind an older unfinished head.
REQ-026 Presented head drives wakeup_active if is_for_lsq=0, else lsq_wakeup_active; never both.
REQ-027 Head pops at an edge where its active=1 and the matching ready=1; otherwise it holds all outputs stable.
REQ-028 is_available = (count<DEPTH) or (head pops this cycle); must not depend combinationally on write_enable.
REQ-029 Simultaneous push and pop at full: both occur and count stays DEPTH.
REQ-030 write_enable=1 with is_available=0: the op is dropped and the unit is unchanged.
REQ-031 Pointers wrap modulo DEPTH.
REQ-032 flush=1: count becomes 0 at the next edge, any same-cycle write is dropped, and both active outputs are forced 0 that cycle.
REQ-033 Empty unit: wakeup_active=lsq_wakeup_active=0 and is_available=1.

Reset
REQ-034 reset_n=0 at an edge empties all slots and sets pointers to 0, illegal_op=0, and both active outputs=0.
REQ-035 Reset takes priority over flush and write; data outputs after reset are don't-care but must not be X-propagated into active flags.
REQ-036 Reset asserted mid-operation discards every in-flight op, and no wakeup is emitted for it afterwards.

Structure
REQ-037 Shared package holds the ALUControl opcode constants, the latency function and a max-latency constant (4).
REQ-038 One sub-module, alu_compute (combinational, XLEN-parametrised): op, lhs, rhs -> result, illegal.
REQ-039 Countdown width = $clog2(max latency+1).

Verification
REQ-040 Reset, then ADD rs1=5 imm=7 ALUSrc=1 tag=3, with ready held 1 -> wakeup_active exactly 1 cycle, 3 cycles after the accept edge, with value 12 and tag 3.
REQ-041 SRA rs1=0x80000010 rs2=4, then pass-through imm=0x1000 on the next cycle -> 0xF8000001 appears first, then 0x1000 the cycle after it (in order).
REQ-042 Fill DEPTH=4 with OR ops and hold wakeup_ready=0 -> is_available=0 and head held stable; raise ready plus write the same cycle -> push accepted and count stays 4.
REQ-043 ADD with is_for_lsq=1, rob_index=9, 2+3 -> lsq_wakeup_active with index 9 and value 5, and wakeup_active remains 0.
REQ-044 Three ops in flight, then flush plus a write the same cycle -> no active outputs after that, is_available=1 next cycle, and the write is not executed.
REQ-045 ALUControl=0110 accepted -> illegal_op pulse, then a result of 0xFFFFFFFF on the following cycle; also assert reset_n=0 mid-SRA -> no wakeup after the reset.
